flp_receiver: RTL



---
 rtl/flp_receiver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flp_receiver.sv
// FLP burst receiver: frames 17 clock / 16 data pulse positions and decodes the 16-bit LCW.
// Optional FLP_MATCH3_EN: publish only after three consecutive identical decoded words.
module flp_receiver #(
    parameter int unsigned SLOT = 1024,
    parameter int unsigned TOL  = 128,
    parameter int unsigned GAP  = 4096,
    parameter int unsigned TW   = 13
) (
    input  logic        CLK16,
    input  logic        RST,
    input  logic        RXp,
    output logic [15:0] lcw,
    output logic        lcw_valid,
    input  logic        lcw_ready,
    output logic        burst_err,
    output logic        nlp_seen,
    output logic        overrun
);

    localparam logic [TW:0]   DATA_LO = (TW+1)'(SLOT - TOL);
    localparam logic [TW:0]   DATA_HI = (TW+1)'(SLOT + TOL);
    localparam logic [TW:0]   CLK_LO  = (TW+1)'(2 * SLOT - TOL);
    localparam logic [TW:0]   CLK_HI  = (TW+1)'(2 * SLOT + TOL);
    localparam logic [TW-1:0] GAP_T   = TW'(GAP);

    typedef enum logic [1:0] {
        StHoldoff,
        StIdle,
        StWait
    } state_t;

    state_t        state;
    logic [2:0]    sync;
    logic          pulse;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic [TW:0]   elapsed;
    logic [3:0]    k;
    logic          data_hit;
    logic [15:0]   shift;
    logic          pub;
    logic          publish;
    logic          in_data;
    logic          in_clk;

    always_ff @(posedge CLK16 or posedge RST) begin
        if (RST) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], RXp};
        end
    end

    assign pulse     = sync[1] & ~sync[2];
    assign timer_inc = (timer == '1) ? timer : timer + TW'(1);
    // timer lags the pulse spacing by one cycle; windows are in cycles between pulse edges
    assign elapsed   = {1'b0, timer} + (TW+1)'(1);
    assign in_data   = (elapsed >= DATA_LO) && (elapsed <= DATA_HI);
    assign in_clk    = (elapsed >= CLK_LO) && (elapsed <= CLK_HI);

    always_ff @(posedge CLK16 or posedge RST) begin
        if (RST) begin
            state     <= StHoldoff;
            timer     <= '0;
            k         <= '0;
            data_hit  <= 1'b0;
            shift     <= '0;
            burst_err <= 1'b0;
            nlp_seen  <= 1'b0;
            pub       <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            nlp_seen  <= 1'b0;
            pub       <= 1'b0;
            timer     <= timer_inc;
            case (state)
                StHoldoff: begin
                    if (pulse) begin
                        timer <= '0;
                    end else if (timer >= GAP_T) begin
                        state <= StIdle;
                        timer <= '0;
                    end
                end
                StIdle: begin
                    if (pulse) begin
                        timer    <= '0;
                        k        <= '0;
                        data_hit <= 1'b0;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (pulse) begin
                        if (in_data && !data_hit) begin
                            data_hit <= 1'b1;
                        end else if (in_clk) begin
                            shift[k] <= data_hit;
                            k        <= k + 4'd1;
                            data_hit <= 1'b0;
                            timer    <= '0;
                            if (k == 4'd15) begin
                                pub   <= 1'b1;
                                state <= StHoldoff;
                            end
                        end else begin
                            burst_err <= 1'b1;
                            state     <= StHoldoff;
                            timer     <= '0;
                        end
                    end else if (elapsed > CLK_HI) begin
                        if (k == 4'd0 && !data_hit) begin
                            nlp_seen <= 1'b1;
                        end else begin
                            burst_err <= 1'b1;
                        end
                        state <= StHoldoff;
                        timer <= '0;
                    end
                end
                default: begin
                    state <= StHoldoff;
                    timer <= '0;
                end
            endcase
        end
    end

`ifdef FLP_MATCH3_EN
    logic [1:0]  match_cnt;
    logic [15:0] last_word;
    logic        match_hit;

    assign match_hit = (shift == last_word) && (match_cnt != 2'd0);

    always_ff @(posedge CLK16 or posedge RST) begin
        if (RST) begin
            match_cnt <= '0;
            last_word <= '0;
        end else if (burst_err || nlp_seen) begin
            match_cnt <= '0;
        end else if (pub) begin
            last_word <= shift;
            if (!match_hit) begin
                match_cnt <= 2'd1;
            end else if (match_cnt != 2'd2) begin
                match_cnt <= match_cnt + 2'd1;
            end
        end
    end

    assign publish = pub && match_hit && (match_cnt == 2'd2);
`else
    assign publish = pub;
`endif

    always_ff @(posedge CLK16 or posedge RST) begin
        if (RST) begin
            lcw       <= '0;
            lcw_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (publish) begin
            lcw       <= shift;
            lcw_valid <= 1'b1;
            if (lcw_valid && !lcw_ready) begin
                overrun <= 1'b1;
            end
        end else if (lcw_valid && lcw_ready) begin
            lcw_valid <= 1'b0;
        end
    end

endmodule
